// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'hD503201F;

    // A fetch faults when it is not word aligned or lands past the last word.
    function automatic logic is_fault(input logic [63:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, registered read, read-before-write on a shared edge.
module imem_array #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents survive reset; reset only suppresses a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we && !reset) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: one outstanding request, fixed latency,
// NOP plus fault flag for misaligned or out-of-range addresses, flushable.
module imem_responder
    import imem_pkg::*;
#(
    parameter int N       = 64,
    parameter int W       = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_F,
    output logic                     req_ready_F,
    input  logic [N-1:0]             imem_addr_F,
    input  logic                     flush_F,
    output logic                     resp_valid_F,
    input  logic                     resp_ready_F,
    output logic [W-1:0]             resp_data_F,
    output logic                     resp_fault_F,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [W-1:0]             load_data,
    output state_t                   state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; ready never looks at valid, and a producer holds valid and its payload
    // stable until the transfer completes.
    logic [CW-1:0] cnt;
    logic [N-1:0]  addr_q;
    logic          accept;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic [W-1:0]  rd_data;
    logic          fault;

    assign req_ready_F = (state == IDLE) && !flush_F;
    assign accept      = req_valid_F && req_ready_F;
    assign fault       = is_fault(64'(addr_q), DEPTH);

    // With zero latency the array is read on the acceptance edge straight from the bus.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = addr_q[AW+1:2];
        if (LATENCY == 0) begin
            rd_en  = accept;
            rd_idx = imem_addr_F[AW+1:2];
        end else begin
            rd_en  = (state == WAIT) && (cnt == CW'(1));
        end
    end

    imem_array #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // RESP spends its first cycle registering the array output, so valid rises
    // LATENCY+1 cycles after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            resp_valid_F <= 1'b0;
            resp_data_F  <= '0;
            resp_fault_F <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= imem_addr_F;
                        cnt    <= CW'(LATENCY);
                        state  <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (flush_F) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (flush_F) begin
                        state        <= IDLE;
                        resp_valid_F <= 1'b0;
                    end else if (!resp_valid_F) begin
                        resp_valid_F <= 1'b1;
                        resp_data_F  <= fault ? W'(NOP) : rd_data;
                        resp_fault_F <= fault;
                    end else if (resp_ready_F) begin
                        state        <= IDLE;
                        resp_valid_F <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 and a LATENCY=0 instance, each
// tracked by a timeline model of its request/response behaviour.
module tb_imem_responder;
    import imem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, req_valid, flush, resp_ready, load_en;
    logic [1:0][63:0] addr;
    logic [1:0][5:0]  load_addr;
    logic [1:0][31:0] load_data;
    logic [1:0]       req_ready, resp_valid, resp_fault;
    logic [1:0][31:0] resp_data;
    state_t           st0, st1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    imem_responder #(.N(64), .W(32), .DEPTH(64), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid_F(req_valid[0]), .req_ready_F(req_ready[0]),
        .imem_addr_F(addr[0]), .flush_F(flush[0]), .resp_valid_F(resp_valid[0]),
        .resp_ready_F(resp_ready[0]), .resp_data_F(resp_data[0]), .resp_fault_F(resp_fault[0]),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]), .state(st0)
    );

    imem_responder #(.N(64), .W(32), .DEPTH(64), .LATENCY(0)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid_F(req_valid[1]), .req_ready_F(req_ready[1]),
        .imem_addr_F(addr[1]), .flush_F(flush[1]), .resp_valid_F(resp_valid[1]),
        .resp_ready_F(resp_ready[1]), .resp_data_F(resp_data[1]), .resp_fault_F(resp_fault[1]),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]), .state(st1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a request is pending from acceptance; the memory is sampled LATENCY
    // edges later and the response shows one edge after that.
    int          lat [2] = '{2, 0};
    bit          busy [2];
    int          age [2];
    bit          vld [2];
    logic [31:0] dat [2];
    bit          flt [2];
    logic [31:0] sd [2];
    bit          sf [2];
    logic [63:0] cap [2];
    logic [31:0] mm [2][64];

    task automatic snap(input int d);
        sf[d] = (cap[d][1:0] != 2'b00) || ((cap[d] >> 2) >= 64);
        sd[d] = sf[d] ? 32'hD503201F : mm[d][cap[d][7:2]];
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                busy[d] = 1'b0; vld[d] = 1'b0; dat[d] = '0; flt[d] = 1'b0;
            end else begin
                if (busy[d] && flush[d]) begin
                    busy[d] = 1'b0; vld[d] = 1'b0;
                end else if (vld[d] && resp_ready[d]) begin
                    busy[d] = 1'b0; vld[d] = 1'b0;
                end else if (!busy[d]) begin
                    if (req_valid[d] && !flush[d]) begin
                        busy[d] = 1'b1; age[d] = 0; cap[d] = addr[d];
                        if (lat[d] == 0) snap(d);
                    end
                end else if (!vld[d]) begin
                    age[d]++;
                    if (age[d] == lat[d]) snap(d);
                    if (age[d] == lat[d] + 1) begin
                        vld[d] = 1'b1; dat[d] = sd[d]; flt[d] = sf[d];
                    end
                end
                if (load_en[d]) mm[d][load_addr[d]] = load_data[d];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("req_ready%0d", d), 64'(req_ready[d]), 64'(!busy[d] && !flush[d]));
                check($sformatf("resp_valid%0d", d), 64'(resp_valid[d]), 64'(vld[d]));
                check($sformatf("resp_data%0d", d), 64'(resp_data[d]), 64'(dat[d]));
                check($sformatf("resp_fault%0d", d), 64'(resp_fault[d]), 64'(flt[d]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input int d, input logic [63:0] a);
        bit ok = 1'b0;
        bit rdy;
        req_valid[d] = 1'b1;
        addr[d]      = a;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            rdy = req_ready[d];
            cyc(1);
            ok = rdy;
        end
        req_valid[d] = 1'b0;
        check("accept_in_time", 64'(ok), 64'(1));
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!resp_valid[d] && n < 20) begin
            cyc(1);
            n++;
        end
        check("valid_in_time", 64'(resp_valid[d]), 64'(1));
    endtask

    task automatic fetch(input int d, input logic [63:0] a, output logic [31:0] data,
                         output logic fault, output int n);
        resp_ready[d] = 1'b0;
        do_req(d, a);
        wait_valid(d, n);
        data  = resp_data[d];
        fault = resp_fault[d];
        resp_ready[d] = 1'b1;
        cyc(1);
        resp_ready[d] = 1'b0;
    endtask

    function automatic logic [31:0] word(input int i);
        case (i)
            0:       return 32'h8B020020;
            1:       return 32'hCB030041;
            2:       return 32'hF8400062;
            3:       return 32'hB4000040;
            63:      return 32'h1F2E3D4C;
            default: return 32'h10000000 + 32'(i);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d_out;
        logic        f_out;
        int          n;

        rst = 2'b11; req_valid = '0; flush = '0; resp_ready = '0; load_en = '0;
        addr = '0; load_addr = '0; load_data = '0;
        cyc(1);
        cmp_en = 1'b1;
        cyc(1);
        rst = 2'b00;
        check("reset_state0", 64'(st0), 64'(IDLE));
        check("reset_valid0", 64'(resp_valid[0]), 64'(0));
        check("reset_data0", 64'(resp_data[0]), 64'(0));

        for (int i = 0; i < 64; i++) begin
            load_en      = 2'b11;
            load_addr[0] = 6'(i); load_addr[1] = 6'(i);
            load_data[0] = word(i); load_data[1] = word(i);
            cyc(1);
        end
        load_en = '0;

        // Reset again with a load pending: the load must be dropped.
        rst = 2'b11;
        load_en[0] = 1'b1; load_addr[0] = '0; load_data[0] = 32'hDEADBEEF;
        cyc(1);
        rst = 2'b00; load_en = '0;
        cyc(1);

        // Basic fetch and backpressure on the LATENCY=2 instance.
        do_req(0, 64'h8);
        check("busy_not_ready", 64'(req_ready[0]), 64'(0));
        wait_valid(0, n);
        check("basic_latency", 64'(n), 64'(3));
        check("basic_data", 64'(resp_data[0]), 64'h0F8400062);
        check("basic_fault", 64'(resp_fault[0]), 64'(0));
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("bp_valid", 64'(resp_valid[0]), 64'(1));
            check("bp_data", 64'(resp_data[0]), 64'h0F8400062);
            check("bp_not_ready", 64'(req_ready[0]), 64'(0));
        end
        resp_ready[0] = 1'b1;
        cyc(1);
        resp_ready[0] = 1'b0;
        check("consumed_valid", 64'(resp_valid[0]), 64'(0));
        check("consumed_ready", 64'(req_ready[0]), 64'(1));

        // Fault boundaries.
        fetch(0, 64'h6, d_out, f_out, n);
        check("misalign_data", 64'(d_out), 64'h0D503201F);
        check("misalign_fault", 64'(f_out), 64'(1));
        fetch(0, 64'h100, d_out, f_out, n);
        check("range_data", 64'(d_out), 64'h0D503201F);
        check("range_fault", 64'(f_out), 64'(1));
        fetch(0, 64'hFC, d_out, f_out, n);
        check("last_word_data", 64'(d_out), 64'h01F2E3D4C);
        check("last_word_fault", 64'(f_out), 64'(0));
        check("last_word_latency", 64'(n), 64'(3));

        // Flush while waiting: nothing may be delivered.
        do_req(0, 64'h4);
        flush[0] = 1'b1;
        cyc(1);
        flush[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("flush_wait_novalid", 64'(resp_valid[0]), 64'(0));
            cyc(1);
        end

        // Flush in RESP together with resp_ready: single clean return to IDLE.
        do_req(0, 64'h0);
        wait_valid(0, n);
        resp_ready[0] = 1'b1; flush[0] = 1'b1;
        cyc(1);
        resp_ready[0] = 1'b0; flush[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("flush_resp_novalid", 64'(resp_valid[0]), 64'(0));
            cyc(1);
        end
        check("flush_resp_data_kept", 64'(resp_data[0]), 64'h08B020020);

        // Flush in IDLE blocks a simultaneous request.
        req_valid[0] = 1'b1; addr[0] = 64'hC; flush[0] = 1'b1;
        #1;
        check("flush_idle_ready", 64'(req_ready[0]), 64'(0));
        cyc(1);
        req_valid[0] = 1'b0; flush[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("flush_idle_novalid", 64'(resp_valid[0]), 64'(0));
            cyc(1);
        end

        // LATENCY=0 instance.
        fetch(1, 64'h0, d_out, f_out, n);
        check("lat0_latency", 64'(n), 64'(1));
        check("lat0_data", 64'(d_out), 64'h08B020020);
        load_en[1] = 1'b1; load_addr[1] = '0; load_data[1] = 32'h11111111;
        resp_ready[1] = 1'b0;
        do_req(1, 64'h0);
        load_en[1] = 1'b0;
        wait_valid(1, n);
        check("lat0_rbw_old", 64'(resp_data[1]), 64'h08B020020);
        resp_ready[1] = 1'b1;
        cyc(1);
        resp_ready[1] = 1'b0;
        load_en[1] = 1'b1; load_data[1] = 32'h22222222;
        cyc(1);
        load_en[1] = 1'b0;
        cyc(1);
        fetch(1, 64'h0, d_out, f_out, n);
        check("lat0_new_data", 64'(d_out), 64'h022222222);
        fetch(1, 64'h101, d_out, f_out, n);
        check("lat0_fault", 64'(f_out), 64'(1));
        check("lat0_fault_data", 64'(d_out), 64'h0D503201F);

        // Reset in WAIT and in RESP.
        do_req(0, 64'h0);
        check("in_wait", 64'(st0), 64'(WAIT));
        rst[0] = 1'b1;
        cyc(1);
        rst[0] = 1'b0;
        check("rst_wait_state", 64'(st0), 64'(IDLE));
        check("rst_wait_valid", 64'(resp_valid[0]), 64'(0));
        check("rst_wait_data", 64'(resp_data[0]), 64'(0));
        do_req(0, 64'hC);
        wait_valid(0, n);
        check("pre_rst_data", 64'(resp_data[0]), 64'h0B4000040);
        rst[0] = 1'b1;
        cyc(1);
        rst[0] = 1'b0;
        check("rst_resp_state", 64'(st0), 64'(IDLE));
        check("rst_resp_valid", 64'(resp_valid[0]), 64'(0));
        check("rst_resp_data", 64'(resp_data[0]), 64'(0));
        fetch(0, 64'h0, d_out, f_out, n);
        check("mem_preserved", 64'(d_out), 64'h08B020020);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch stage's instruction-address interface.
- Accepts one fetch address per handshake and waits a configurable number of cycles to model memory latency.
- Returns the 32-bit instruction word, or a NOP with a fault flag for misaligned or out-of-range addresses.
- Has a load port for program preload and a flush input so a taken branch can abort an in-flight fetch.

Parameters:
- N, 64, address width (matches fetch PC width).
- W, 32, instruction width.
- DEPTH, 64, number of instruction words; power of two, ≥2.
- LATENCY, 2, wait cycles between request acceptance and the memory read; 0 is legal.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_F  input  1  fetch presents an address.
- req_ready_F  output  1  responder can accept an address.
- imem_addr_F  input  N  byte address of the instruction.
- flush_F  input  1  abort any in-flight request (branch taken).
- resp_valid_F  output  1  response holds valid data.
- resp_ready_F  input  1  fetch consumes the response.
- resp_data_F  output  W  instruction word.
- resp_fault_F  output  1  address was misaligned or out of range.
- load_en  input  1  write one word into the array.
- load_addr  input  $clog2(DEPTH)  word index for the load.
- load_data  input  W  word to write.

Behaviour:
- Reset (synchronous, sampled on clk rising edge):
  - state=IDLE, wait counter=0, captured address=0.
  - resp_valid_F=0, resp_data_F=0, resp_fault_F=0.
  - Array contents are preserved.
  - Reset overrides flush, handshake and load in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- req_ready_F = (state==IDLE) && !flush_F. This is combinational and must not depend on req_valid_F.
- Acceptance: req_valid_F && req_ready_F at a rising edge. The address is captured and the wait counter is set to LATENCY.
  - If LATENCY>0: next state is WAIT.
  - If LATENCY==0: next state is RESP.
- WAIT: the counter decrements each cycle. When it reaches 1, the array is read at the captured word index; the result is registered into resp_data_F/resp_fault_F and the state moves to RESP.
- Latency: resp_valid_F rises exactly LATENCY+1 cycles after the acceptance edge.
- RESP: resp_valid_F=1. The state holds, with data and fault stable, until resp_ready_F=1. It then returns to IDLE on that edge. A new request is accepted no earlier than the following cycle (one request outstanding, no back-to-back).
- Fault rule, evaluated on the captured address:
  - fault if addr[1:0]!=0, or if addr[N-1:2] >= DEPTH.
  - When faulting, resp_data_F = NOP (0xD503201F) and resp_fault_F=1.
  - Otherwise resp_data_F = mem[addr[$clog2(DEPTH)+1:2]] and resp_fault_F=0.
- Flush:
  - flush_F=1 in WAIT or RESP: next state is IDLE, resp_valid_F=0 next cycle, nothing delivered.
  - Flush in IDLE blocks acceptance that cycle.
  - Flush in RESP wins over a simultaneous resp_ready_F; the result is the same IDLE transition.
- Load:
  - Writes mem[load_addr] at the edge in any state.
  - A load to the same word in the same cycle as the array read returns the old data (read-before-write).
  - Loads in earlier cycles are visible.
- resp_data_F/resp_fault_F keep their last value after the response is consumed; only resp_valid_F qualifies them.

Decomposition:
- Package imem_pkg: state enum (IDLE, WAIT, RESP), NOP constant 32'hD503201F, fault-check function taking address and DEPTH.
- Sub-module imem_array: DEPTH×W, synchronous write, registered read enable, read-before-write.
- The responder owns the FSM, counter, address capture and fault logic.

Test Plan:
- Basic fetch: preload mem[0..3]=0x8B020020,0xCB030041,0xF8400062,0xB4000040; reset; request addr 0x8 with LATENCY=2 → resp_valid_F 3 cycles after acceptance, data 0xF8400062, fault 0; req_ready_F low until resp_ready_F.
- Backpressure: hold resp_ready_F=0 for 5 cycles → resp_valid_F/resp_data_F stable all 5 cycles; accept on 6th → IDLE, req_ready_F=1 next cycle.
- Faults: addr 0x6 → data 0xD503201F, fault 1; addr DEPTH*4 (0x100) → same; addr 0xFC → mem[63], fault 0.
- Flush: accept addr 0x4, assert flush_F one cycle later → no resp_valid_F ever; flush in RESP with resp_ready_F=1 → IDLE, no duplicate. flush_F with req_valid_F in IDLE → req_ready_F=0, not accepted.
- LATENCY=0 build: request addr 0x0 → resp_valid_F on the next cycle with mem[0]. A load to word 0 in the acceptance cycle returns old data; a load two cycles earlier returns new data.
- Reset mid-operation: reset asserted in WAIT and in RESP → next cycle state IDLE, resp_valid_F=0, resp_data_F=0, memory contents unchanged (re-read of addr 0x0 returns 0x8B020020).
